kb_scancode_seq: RTL

//  Sequences raw PS/2 set-2 bytes from the keyboard receiver into single key events for the

---
 rtl/kb_scancode_seq.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/kb_scancode_seq.sv
// rtl/kb_scancode_seq.sv - PS/2 set-2 byte sequencer: prefix decode, modifier tracking, make-code strobes
module kb_scancode_seq #(
    parameter int TIMEOUT   = 50000,
    parameter bit REPEAT_EN = 1'b0
) (
    input  logic       clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_code,
    input  logic       i_code_valid,
    output logic [7:0] o_scancode,
    output logic       o_valid,
    output logic       o_shift,
    output logic       o_capslock,
    output logic       o_err
);
    localparam int            CW      = $clog2(TIMEOUT);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    localparam logic [7:0] C_LSHIFT = 8'h12;
    localparam logic [7:0] C_RSHIFT = 8'h59;
    localparam logic [7:0] C_CAPS   = 8'h58;
    localparam logic [7:0] C_EXT    = 8'hE0;
    localparam logic [7:0] C_BRK    = 8'hF0;
    localparam logic [7:0] C_PAUSE  = 8'hE1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK,
        S_PAUSE
    } state_t;

    state_t        state_q, state_d, cur_state;
    logic [2:0]    skip_q, skip_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    scancode_q, scancode_d;
    logic [7:0]    last_make_q, last_make_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          lshift_q, lshift_d;
    logic          rshift_q, rshift_d;
    logic          shift_q, shift_d;
    logic          caps_held_q, caps_held_d;
    logic          capslock_q, capslock_d;
    logic          overrun;

    assign overrun = (i_code == 8'h00) || (i_code == 8'hFF);

    always_comb begin
        state_d     = state_q;
        skip_d      = skip_q;
        cnt_d       = '0;
        scancode_d  = scancode_q;
        last_make_d = last_make_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        caps_held_d = caps_held_q;
        capslock_d  = capslock_q;
        cur_state   = state_q;

        // Expiry takes priority: a byte landing on this cycle is decoded as if from IDLE.
        if (state_q != S_IDLE && cnt_q == TO_LAST) begin
            err_d     = 1'b1;
            state_d   = S_IDLE;
            cur_state = S_IDLE;
        end

        if (i_code_valid) begin
            if (overrun) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end else begin
                case (cur_state)
                    S_IDLE: begin
                        state_d = S_IDLE;
                        if (i_code == C_EXT) begin
                            state_d = S_EXT;
                        end else if (i_code == C_BRK) begin
                            state_d = S_BRK;
                        end else if (i_code == C_PAUSE) begin
                            state_d = S_PAUSE;
                            skip_d  = 3'd7;
                        end else if (i_code == C_LSHIFT) begin
                            lshift_d = 1'b1;
                        end else if (i_code == C_RSHIFT) begin
                            rshift_d = 1'b1;
                        end else if (i_code == C_CAPS) begin
                            if (!caps_held_q) capslock_d = ~capslock_q;
                            caps_held_d = 1'b1;
                        end else begin
                            if (REPEAT_EN || i_code != last_make_q) begin
                                scancode_d = i_code;
                                valid_d    = 1'b1;
                            end
                            last_make_d = i_code;
                        end
                    end
                    S_EXT: begin
                        state_d = (i_code == C_BRK) ? S_EXT_BRK : S_IDLE;
                    end
                    S_BRK: begin
                        state_d = S_IDLE;
                        if (i_code == C_LSHIFT) lshift_d = 1'b0;
                        if (i_code == C_RSHIFT) rshift_d = 1'b0;
                        if (i_code == C_CAPS) caps_held_d = 1'b0;
                        if (i_code == last_make_q) last_make_d = 8'h00;
                    end
                    S_EXT_BRK: begin
                        state_d = S_IDLE;
                    end
                    S_PAUSE: begin
                        skip_d = skip_q - 3'd1;
                        if (skip_q == 3'd1) state_d = S_IDLE;
                    end
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end
        end else if (cur_state != S_IDLE) begin
            cnt_d = cnt_q + 1'b1;
        end

        shift_d = lshift_d | rshift_d;
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            skip_q      <= '0;
            cnt_q       <= '0;
            scancode_q  <= '0;
            last_make_q <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            shift_q     <= 1'b0;
            caps_held_q <= 1'b0;
            capslock_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            cnt_q       <= cnt_d;
            scancode_q  <= scancode_d;
            last_make_q <= last_make_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            shift_q     <= shift_d;
            caps_held_q <= caps_held_d;
            capslock_q  <= capslock_d;
        end
    end

    assign o_scancode = scancode_q;
    assign o_valid    = valid_q;
    assign o_shift    = shift_q;
    assign o_capslock = capslock_q;
    assign o_err      = err_q;

endmodule
